// File: rtl/cdb_tag_return.sv
// cdb_tag_return: collects completed tag/result pairs from NUM_FU functional
// units into one holding slot each and broadcasts them round-robin onto the
// common data bus. The registered broadcast doubles as the free-tag FIFO
// write port; tf_full stalls all broadcasts.
// Optional build macro CDB_STALL_CNT_EN adds a saturating stall_cnt output
// counting edges where results are pending but the tag FIFO is full.
module cdb_tag_return #(
  parameter int NUM_FU     = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  localparam int FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic                         tf_full,
  output logic                         cdb_valid,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [FU_W-1:0]              cdb_fu
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  logic [NUM_FU-1:0]     occ;
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_FU];
  logic [DATA_WIDTH-1:0] data_q [NUM_FU];
  logic [FU_W-1:0]       rr_ptr;

  logic                  found;
  logic [FU_W-1:0]       grant_idx;
  logic                  grant;

  // Ready is pure registered state so FUs never see a combinational path from grant.
  assign fu_ready = ~occ;

  // Round-robin search: first occupied slot at or above rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && occ[idx]) begin
        found     = 1'b1;
        grant_idx = FU_W'(idx);
      end
    end
  end

  // A full tag FIFO blocks every broadcast.
  assign grant = found & ~tf_full;

  // Holding slots: load when empty, free when granted; flush drops everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant && (grant_idx == FU_W'(i))) begin
          occ[i] <= 1'b0;
        end else if (fu_valid[i] && !occ[i]) begin
          occ[i]    <= 1'b1;
          tag_q[i]  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
          data_q[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Broadcast register and round-robin pointer; payload holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_fu    <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (grant) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= tag_q[grant_idx];
      cdb_data  <= data_q[grant_idx];
      cdb_fu    <= grant_idx;
      rr_ptr    <= (grant_idx == FU_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_STALL_CNT_EN
  // Saturating count of edges where results wait behind a full tag FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if ((|occ) && tf_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_tag_return.sv
// Directed bench for cdb_tag_return with NUM_FU=4, TAG_WIDTH=6, DATA_WIDTH=32.
module tb_cdb_tag_return;

  logic         clk;
  logic         reset;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [23:0]  fu_tag;
  logic [127:0] fu_data;
  logic [3:0]   fu_ready;
  logic         tf_full;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_fu;
`ifdef CDB_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int checks;
  int failures;

  cdb_tag_return #(.NUM_FU(4), .TAG_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .fu_ready  (fu_ready),
    .tf_full   (tf_full),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_fu    (cdb_fu)
`ifdef CDB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [5:0] t, input logic [31:0] d);
    fu_valid[i]        = v;
    fu_tag[i*6 +: 6]   = t;
    fu_data[i*32 +: 32] = d;
  endtask

  task automatic chk_bcast(input string tag, input logic [5:0] t, input logic [1:0] f);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'(1'b1));
    chk({tag, "_tag"},   64'(cdb_tag),   64'(t));
    chk({tag, "_fu"},    64'(cdb_fu),    64'(f));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    flush    = 1'b0;
    tf_full  = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;

    tick();
    tick();
    chk("rst_valid", 64'(cdb_valid), 64'(1'b0));
    chk("rst_tag",   64'(cdb_tag),   64'(6'h00));
    chk("rst_data",  64'(cdb_data),  64'(32'h0));
    chk("rst_fu",    64'(cdb_fu),    64'(2'd0));
    chk("rst_ready", 64'(fu_ready),  64'(4'hF));
`ifdef CDB_STALL_CNT_EN
    chk("rst_stall", 64'(stall_cnt), 64'(16'd0));
`endif
    reset = 1'b1;
    tick();

    // Single request from FU0.
    set_fu(0, 1'b1, 6'h05, 32'hA5);
    tick();
    set_fu(0, 1'b0, 6'h00, 32'h0);
    chk("single_ready_busy", 64'(fu_ready),  64'(4'b1110));
    chk("single_no_bcast",   64'(cdb_valid), 64'(1'b0));
    tick();
    chk_bcast("single", 6'h05, 2'd0);
    chk("single_data",       64'(cdb_data), 64'(32'hA5));
    chk("single_ready_free", 64'(fu_ready), 64'(4'b1111));
    tick();
    chk("single_idle",     64'(cdb_valid), 64'(1'b0));
    chk("single_tag_hold", 64'(cdb_tag),   64'(6'h05));

    // Flush to return rr_ptr to 0, then all four FUs at once.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 6'(6'h10 + i), 32'(100 + i));
    tick();
    fu_valid = '0;
    chk("all_ready_busy", 64'(fu_ready), 64'(4'b0000));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_bcast($sformatf("all%0d", k), 6'(6'h10 + k), 2'(k));
      chk($sformatf("all%0d_data", k), 64'(cdb_data), 64'(32'(100 + k)));
    end
    tick();
    chk("all_gap_end", 64'(cdb_valid), 64'(1'b0));

    // Wrap: rr_ptr back at 0 after FU3; FU0 and FU3 pending.
    set_fu(0, 1'b1, 6'h20, 32'h20);
    set_fu(3, 1'b1, 6'h23, 32'h23);
    tick();
    fu_valid = '0;
    tick();
    chk_bcast("wrap_first", 6'h20, 2'd0);
    tick();
    chk_bcast("wrap_second", 6'h23, 2'd3);

    // Rotation: grant FU1 alone (rr->2), then FU0 and FU2 pending -> FU2 first.
    set_fu(1, 1'b1, 6'h21, 32'h21);
    tick();
    fu_valid = '0;
    tick();
    chk_bcast("rot_fu1", 6'h21, 2'd1);
    set_fu(0, 1'b1, 6'h30, 32'h30);
    set_fu(2, 1'b1, 6'h32, 32'h32);
    tick();
    fu_valid = '0;
    tick();
    chk_bcast("rot_first", 6'h32, 2'd2);
    tick();
    chk_bcast("rot_second", 6'h30, 2'd0);
    tick();

    // Backpressure: slots 1,2 load while tf_full, then five stalled edges.
    tf_full = 1'b1;
    set_fu(1, 1'b1, 6'h01, 32'h1);
    set_fu(2, 1'b1, 6'h02, 32'h2);
    tick();
    fu_valid = '0;
    chk("bp_loaded", 64'(fu_ready), 64'(4'b1001));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_stall%0d_valid", k), 64'(cdb_valid), 64'(1'b0));
      chk($sformatf("bp_stall%0d_ready", k), 64'(fu_ready),  64'(4'b1001));
    end
    tf_full = 1'b0;
    tick();
    chk_bcast("bp_first", 6'h01, 2'd1);
    tick();
    chk_bcast("bp_second", 6'h02, 2'd2);
`ifdef CDB_STALL_CNT_EN
    chk("bp_stall_cnt", 64'(stall_cnt), 64'(16'd5));
`endif
    tick();

    // Flush with three slots pending and FU2 requesting at the flush edge.
    set_fu(0, 1'b1, 6'h30, 32'h30);
    set_fu(1, 1'b1, 6'h31, 32'h31);
    set_fu(3, 1'b1, 6'h33, 32'h33);
    tick();
    fu_valid = '0;
    chk("fl_pending", 64'(fu_ready), 64'(4'b0100));
    flush = 1'b1;
    set_fu(2, 1'b1, 6'h32, 32'h32);
    tick();
    flush    = 1'b0;
    fu_valid = '0;
    chk("fl_valid", 64'(cdb_valid), 64'(1'b0));
    chk("fl_ready", 64'(fu_ready),  64'(4'b1111));
`ifdef CDB_STALL_CNT_EN
    chk("fl_stall_clr", 64'(stall_cnt), 64'(16'd0));
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_quiet%0d", k), 64'(cdb_valid), 64'(1'b0));
    end
    chk("fl_tag_hold", 64'(cdb_tag), 64'(6'h02));

    // Async reset during a broadcast, with FU2 still pending.
    set_fu(1, 1'b1, 6'h3F, 32'hDEADBEEF);
    tick();
    set_fu(1, 1'b0, 6'h00, 32'h0);
    set_fu(2, 1'b1, 6'h12, 32'h12);
    tick();
    fu_valid = '0;
    chk_bcast("ar_bcast", 6'h3F, 2'd1);
    chk("ar_data",    64'(cdb_data), 64'(32'hDEADBEEF));
    chk("ar_pending", 64'(fu_ready), 64'(4'b1011));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 64'(cdb_valid), 64'(1'b0));
    chk("ar_ready", 64'(fu_ready),  64'(4'b1111));
    chk("ar_tag",   64'(cdb_tag),   64'(6'h00));
    tick();
    reset = 1'b1;
    tick();
    chk("ar_after", 64'(cdb_valid), 64'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
